// File: rtl/wrr_arb_pkg.sv
// ============================================================================
// Module : wrr_arb_pkg
// Brief  : Shared state encoding and width helpers for wrr_input_arbiter.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

package wrr_arb_pkg;

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        WR_PKT = 1'b1
    } arb_state_t;

    function automatic int queue_idx_width(input int num_queues);
        return (num_queues > 1) ? $clog2(num_queues) : 1;
    endfunction

    function automatic int credit_width(input int weight_width);
        return weight_width;
    endfunction

endpackage

`default_nettype wire

// File: rtl/small_fifo.sv
// ============================================================================
// Module : small_fifo
// Brief  : Show-ahead FIFO; dout is the head word whenever empty is low.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module small_fifo #(
    parameter int WIDTH          = 72,
    parameter int MAX_DEPTH_BITS = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] din,
    input  logic             wr_en,
    input  logic             rd_en,
    output logic [WIDTH-1:0] dout,
    output logic             nearly_full,
    output logic             empty
);

    localparam int c_DEPTH = 1 << MAX_DEPTH_BITS;
    localparam logic [MAX_DEPTH_BITS:0] c_FULL_CNT = c_DEPTH[MAX_DEPTH_BITS:0];
    localparam logic [MAX_DEPTH_BITS:0] c_NFULL_CNT = c_FULL_CNT - 1'b1;

    logic [WIDTH-1:0]          r_mem [c_DEPTH];
    logic [MAX_DEPTH_BITS-1:0] r_wr_ptr;
    logic [MAX_DEPTH_BITS-1:0] r_rd_ptr;
    logic [MAX_DEPTH_BITS:0]   r_count;
    logic                      w_full;
    logic                      w_push;
    logic                      w_pop;

    assign w_full      = (r_count == c_FULL_CNT);
    assign empty       = (r_count == '0);
    assign nearly_full = (r_count >= c_NFULL_CNT);
    // A write into a full FIFO is dropped, even if a pop happens the same cycle.
    assign w_push      = wr_en && !w_full;
    assign w_pop       = rd_en && !empty;
    assign dout        = r_mem[r_rd_ptr];

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            if (w_push && !w_pop)      r_count <= r_count + 1'b1;
            else if (w_pop && !w_push) r_count <= r_count - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= din;
    end

endmodule

`default_nettype wire

// File: rtl/wrr_input_arbiter.sv
// ============================================================================
// Module : wrr_input_arbiter
// Brief  : Packet-granular weighted round-robin arbiter over per-queue FIFOs.
//          Define WRR_ARB_STATS_EN to add per-queue packet counters (pkt_count).
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module wrr_input_arbiter
    import wrr_arb_pkg::*;
#(
    parameter int DATA_WIDTH      = 64,
    parameter int CTRL_WIDTH      = DATA_WIDTH / 8,
    parameter int NUM_QUEUES      = 8,
    parameter int WEIGHT_WIDTH    = 4,
    parameter int FIFO_DEPTH_BITS = 2,
    parameter int STAGE_NUMBER    = 2
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [NUM_QUEUES*DATA_WIDTH-1:0]   in_data,
    input  logic [NUM_QUEUES*CTRL_WIDTH-1:0]   in_ctrl,
    input  logic [NUM_QUEUES-1:0]              in_wr,
    output logic [NUM_QUEUES-1:0]              in_rdy,
    input  logic [NUM_QUEUES*WEIGHT_WIDTH-1:0] weights,
    output logic [DATA_WIDTH-1:0]              out_data,
    output logic [CTRL_WIDTH-1:0]              out_ctrl,
    output logic                               out_wr,
    input  logic                               out_rdy
`ifdef WRR_ARB_STATS_EN
    ,
    output logic [NUM_QUEUES*32-1:0]           pkt_count
`endif
);

    localparam int c_QW = queue_idx_width(NUM_QUEUES);
    localparam int c_CW = credit_width(WEIGHT_WIDTH);
    localparam int c_FW = DATA_WIDTH + CTRL_WIDTH;
    localparam logic [c_QW-1:0] c_LAST_Q = c_QW'(NUM_QUEUES - 1);

    arb_state_t        r_state;
    arb_state_t        w_state_nxt;
    logic [c_QW-1:0]   r_cur;
    logic [c_CW-1:0]   r_credit;
    logic              r_seen_data;

    logic [c_FW-1:0]         w_fifo_dout [NUM_QUEUES];
    logic [c_CW-1:0]         w_weight    [NUM_QUEUES];
    logic [NUM_QUEUES-1:0]   w_empty;
    logic [NUM_QUEUES-1:0]   w_nearly_full;
    logic [NUM_QUEUES-1:0]   w_rd_en;

    logic [c_FW-1:0]       w_head;
    logic [DATA_WIDTH-1:0] w_head_data;
    logic [CTRL_WIDTH-1:0] w_head_ctrl;
    logic                  w_cur_empty;
    logic                  w_is_eop;
    logic [c_QW-1:0]       w_next_q;
    logic                  w_pop;
    logic                  w_advance;
    logic                  w_eop_wr;

    for (genvar i = 0; i < NUM_QUEUES; i++) begin : g_queue
        small_fifo #(
            .WIDTH          (c_FW),
            .MAX_DEPTH_BITS (FIFO_DEPTH_BITS)
        ) u_fifo (
            .clk         (clk),
            .reset       (reset),
            .din         ({in_ctrl[i*CTRL_WIDTH +: CTRL_WIDTH], in_data[i*DATA_WIDTH +: DATA_WIDTH]}),
            .wr_en       (in_wr[i]),
            .rd_en       (w_rd_en[i]),
            .dout        (w_fifo_dout[i]),
            .nearly_full (w_nearly_full[i]),
            .empty       (w_empty[i])
        );
        assign w_weight[i] = weights[i*WEIGHT_WIDTH +: WEIGHT_WIDTH];
        assign w_rd_en[i]  = w_pop && (r_cur == c_QW'(i));
        assign in_rdy[i]   = !w_nearly_full[i];
    end

    assign w_head      = w_fifo_dout[r_cur];
    assign w_head_data = w_head[DATA_WIDTH-1:0];
    assign w_head_ctrl = w_head[c_FW-1 -: CTRL_WIDTH];
    assign w_cur_empty = w_empty[r_cur];
    // Header words carry non-zero ctrl too, so EOP needs a prior ctrl==0 word.
    assign w_is_eop    = (w_head_ctrl != '0) && r_seen_data;
    assign w_next_q    = (r_cur == c_LAST_Q) ? '0 : r_cur + 1'b1;

    always_comb begin
        w_state_nxt = r_state;
        w_pop       = 1'b0;
        w_advance   = 1'b0;
        w_eop_wr    = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (out_rdy) begin
                    if (!w_cur_empty && (r_credit != '0)) begin
                        w_pop       = 1'b1;
                        w_state_nxt = WR_PKT;
                    end else begin
                        w_advance = 1'b1;
                    end
                end
            end
            WR_PKT: begin
                if (out_rdy && !w_cur_empty) begin
                    w_pop = 1'b1;
                    if (w_is_eop) begin
                        w_eop_wr    = 1'b1;
                        w_state_nxt = IDLE;
                    end
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= IDLE;
            r_cur       <= '0;
            r_credit    <= w_weight[0];
            r_seen_data <= 1'b0;
            out_wr      <= 1'b0;
            out_data    <= '0;
            out_ctrl    <= '0;
        end else begin
            r_state <= w_state_nxt;
            out_wr  <= w_pop;
            if (w_pop) begin
                out_data    <= w_head_data;
                out_ctrl    <= w_head_ctrl;
                r_seen_data <= w_eop_wr ? 1'b0 : (r_seen_data || (w_head_ctrl == '0));
            end
            // Credit is only reloaded on arrival at a queue, so weight changes wait for it.
            if (w_advance) begin
                r_cur    <= w_next_q;
                r_credit <= w_weight[w_next_q];
            end else if (w_eop_wr) begin
                r_credit <= r_credit - 1'b1;
            end
        end
    end

`ifdef WRR_ARB_STATS_EN
    for (genvar i = 0; i < NUM_QUEUES; i++) begin : g_stats
        logic [31:0] r_pkt_cnt;
        always_ff @(posedge clk) begin
            if (reset)                                 r_pkt_cnt <= '0;
            else if (w_eop_wr && (r_cur == c_QW'(i)))  r_pkt_cnt <= r_pkt_cnt + 32'd1;
        end
        assign pkt_count[i*32 +: 32] = r_pkt_cnt;
    end
`endif

endmodule

`default_nettype wire

// File: tb/tb_wrr_input_arbiter.sv
// ============================================================================
// Module : tb_wrr_input_arbiter
// Brief  : Directed self-checking bench for wrr_input_arbiter.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_wrr_input_arbiter;

    localparam int DW = 64;
    localparam int CW = 8;
    localparam int NQ = 8;
    localparam int WW = 4;

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic [NQ*DW-1:0] in_data = '0;
    logic [NQ*CW-1:0] in_ctrl = '0;
    logic [NQ-1:0]    in_wr = '0;
    logic [NQ-1:0]    in_rdy;
    logic [NQ*WW-1:0] weights = '0;
    logic [DW-1:0]    out_data;
    logic [CW-1:0]    out_ctrl;
    logic             out_wr;
    logic             out_rdy = 1'b0;
`ifdef WRR_ARB_STATS_EN
    logic [NQ*32-1:0] pkt_count;
`endif

    int n_checks = 0;
    int n_pass   = 0;

    logic [DW-1:0] got_d [$];
    logic [CW-1:0] got_c [$];

    always #5 clk = ~clk;

    wrr_input_arbiter #(
        .DATA_WIDTH      (DW),
        .CTRL_WIDTH      (CW),
        .NUM_QUEUES      (NQ),
        .WEIGHT_WIDTH    (WW),
        .FIFO_DEPTH_BITS (2),
        .STAGE_NUMBER    (2)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .in_data   (in_data),
        .in_ctrl   (in_ctrl),
        .in_wr     (in_wr),
        .in_rdy    (in_rdy),
        .weights   (weights),
        .out_data  (out_data),
        .out_ctrl  (out_ctrl),
        .out_wr    (out_wr),
        .out_rdy   (out_rdy)
`ifdef WRR_ARB_STATS_EN
        ,
        .pkt_count (pkt_count)
`endif
    );

    always @(posedge clk) begin
        #1;
        if (out_wr) begin
            got_d.push_back(out_data);
            got_c.push_back(out_ctrl);
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    function automatic logic [63:0] mk(input int q, input int id, input int i);
        return {32'(q), 16'(id), 16'(i)};
    endfunction

    task automatic set_weight(input int q, input int w);
        weights[q*WW +: WW] = WW'(w);
    endtask

    task automatic do_reset();
        reset   = 1'b1;
        in_wr   = '0;
        out_rdy = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        got_d.delete();
        got_c.delete();
    endtask

    task automatic push_word(input int q, input logic [63:0] d, input logic [7:0] c);
        int t = 0;
        while (!in_rdy[q] && t < 300) begin
            @(posedge clk);
            #1;
            t++;
        end
        if (!in_rdy[q]) begin
            check("push_timeout", 64'(in_rdy[q]), 64'd1);
        end else begin
            in_data[q*DW +: DW] = d;
            in_ctrl[q*CW +: CW] = c;
            in_wr[q] = 1'b1;
            @(posedge clk);
            #1;
            in_wr[q] = 1'b0;
        end
    endtask

    task automatic push_pkt(input int q, input int id, input int n, input bit hdr);
        for (int i = 0; i < n; i++) begin
            push_word(q, mk(q, id, i), (i == n - 1) ? 8'hFF : ((i == 0 && hdr) ? 8'h02 : 8'h00));
        end
    endtask

    task automatic wait_words(input int n, input int budget);
        int t = 0;
        while (got_d.size() < n && t < budget) begin
            @(posedge clk);
            #2;
            t++;
        end
    endtask

    task automatic check_order(input string tag, input int exp[8], input int n);
        int q[$];
        foreach (got_c[k]) if (got_c[k] == 8'hFF) q.push_back(int'(got_d[k][63:32]));
        check({tag, "_npkt"}, 64'(q.size()), 64'(n));
        for (int i = 0; i < n; i++) begin
            check($sformatf("%s_pkt%0d", tag, i), (i < q.size()) ? 64'(q[i]) : 64'hDEAD, 64'(exp[i]));
        end
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int exp_a[8];
        int t;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_out_wr",   64'(out_wr),   64'd0);
        check("rst_out_data", out_data,      64'd0);
        check("rst_out_ctrl", 64'(out_ctrl), 64'd0);
        check("rst_in_rdy",   64'(in_rdy),   64'hFF);
        reset = 1'b0;

        // Weighted order: weights {2,1,0,...}, 4 packets each on q0/q1
        weights = '0;
        set_weight(0, 2);
        set_weight(1, 1);
        do_reset();
        fork
            for (int p = 0; p < 4; p++) push_pkt(0, p, 2, 1'b0);
            for (int p = 0; p < 4; p++) push_pkt(1, p, 2, 1'b0);
            begin
                repeat (6) @(posedge clk);
                #1;
                out_rdy = 1'b1;
            end
        join
        wait_words(16, 200);
        check("wrr_nwords", 64'(got_d.size()), 64'd16);
        exp_a = '{0, 0, 1, 0, 0, 1, 1, 1};
        check_order("wrr", exp_a, 8);

        // One 5-word packet under toggling out_rdy
        weights = '0;
        set_weight(0, 1);
        do_reset();
        fork
            push_pkt(0, 5, 5, 1'b1);
            begin
                out_rdy = 1'b1;
                repeat (30) begin
                    @(posedge clk);
                    #1;
                    out_rdy = ~out_rdy;
                end
            end
        join
        out_rdy = 1'b1;
        wait_words(5, 50);
        repeat (5) @(posedge clk);
        #2;
        check("bp_nwords", 64'(got_d.size()), 64'd5);
        for (int i = 0; i < 5; i++) begin
            check($sformatf("bp_data%0d", i), (i < got_d.size()) ? got_d[i] : 64'hDEAD, mk(0, 5, i));
            check($sformatf("bp_ctrl%0d", i), (i < got_c.size()) ? 64'(got_c[i]) : 64'hDEAD,
                  (i == 4) ? 64'hFF : ((i == 0) ? 64'h02 : 64'h00));
        end

        // Zero weight on a loaded queue
        weights = '0;
        for (int q = 0; q < NQ; q++) set_weight(q, 1);
        set_weight(2, 0);
        do_reset();
        push_pkt(2, 0, 2, 1'b0);
        out_rdy = 1'b1;
        repeat (40) @(posedge clk);
        #2;
        check("w0_q2_nwords", 64'(got_d.size()), 64'd0);

        // All weights zero
        weights = '0;
        do_reset();
        push_pkt(3, 0, 2, 1'b0);
        out_rdy = 1'b1;
        repeat (40) @(posedge clk);
        #2;
        check("w0_all_nwords", 64'(got_d.size()), 64'd0);

        // Reset on the third word of a packet
        weights = '0;
        set_weight(0, 1);
        do_reset();
        out_rdy = 1'b1;
        fork
            push_pkt(0, 7, 5, 1'b1);
            begin
                t = 0;
                while (got_d.size() < 3 && t < 100) begin
                    @(posedge clk);
                    #2;
                    t++;
                end
                check("mid_seen3", 64'(got_d.size()), 64'd3);
                reset = 1'b1;
                @(posedge clk);
                #1;
                check("mid_out_wr", 64'(out_wr), 64'd0);
                reset = 1'b0;
            end
        join
        check("mid_in_rdy", 64'(in_rdy), 64'hFF);
        repeat (12) @(posedge clk);
        #2;
        check("mid_no_more", 64'(got_d.size()), 64'd3);
        got_d.delete();
        got_c.delete();
        push_pkt(0, 8, 3, 1'b0);
        wait_words(3, 60);
        check("post_nwords", 64'(got_d.size()), 64'd3);
        for (int i = 0; i < 3; i++) begin
            check($sformatf("post_data%0d", i), (i < got_d.size()) ? got_d[i] : 64'hDEAD, mk(0, 8, i));
        end
        check("post_eop_ctrl", (got_c.size() > 2) ? 64'(got_c[2]) : 64'hDEAD, 64'hFF);

        // Wrap-around alternation between the last queue and queue 0
        weights = '0;
        set_weight(0, 1);
        set_weight(NQ - 1, 1);
        do_reset();
        push_pkt(0, 0, 2, 1'b0);
        push_pkt(NQ - 1, 0, 2, 1'b0);
        fork
            push_pkt(0, 1, 2, 1'b0);
            push_pkt(NQ - 1, 1, 2, 1'b0);
            out_rdy = 1'b1;
        join
        wait_words(8, 200);
        exp_a = '{0, NQ - 1, 0, NQ - 1, 0, 0, 0, 0};
        check_order("wrap", exp_a, 4);

`ifdef WRR_ARB_STATS_EN
        weights = '0;
        set_weight(1, 1);
        do_reset();
        out_rdy = 1'b1;
        for (int p = 0; p < 3; p++) push_pkt(1, p, 2, 1'b0);
        wait_words(6, 100);
        repeat (2) @(posedge clk);
        #2;
        for (int q = 0; q < NQ; q++) begin
            check($sformatf("stats_q%0d", q), 64'(pkt_count[q*32 +: 32]), (q == 1) ? 64'd3 : 64'd0);
        end
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
